// File: rtl/vscpu_pkg.sv
// Shared definitions for the VerySimpleCPU memory subsystem.
//   ADDR_W_DEF / DATA_W_DEF / LOCK_MAX_DEF : default widths and lock bound
//   owner_t                                : which port currently holds a lock
//   P0 / P1                                : port index constants
package vscpu_pkg;

   localparam int ADDR_W_DEF   = 14;
   localparam int DATA_W_DEF   = 32;
   localparam int LOCK_MAX_DEF = 16;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_P0   = 2'd1,
      OWN_P1   = 2'd2
   } owner_t;

   localparam logic P0 = 1'b0;
   localparam logic P1 = 1'b1;

   function automatic owner_t owner_of(input logic port);
      return port ? OWN_P1 : OWN_P0;
   endfunction

endpackage

// File: rtl/rr_lock_arbiter.sv
// Two-port round-robin arbiter with a bounded ownership lock.
//   clk, rst         : clock, synchronous active-high reset
//   req0/req1        : port requests
//   lock0/lock1      : port wants to keep ownership after this grant
//   gnt0/gnt1        : combinational grants (at most one high)
//   owner, lock_cnt  : ownership state, also exported for observation
module rr_lock_arbiter
   import vscpu_pkg::*;
#(
   parameter  int LOCK_MAX = LOCK_MAX_DEF,
   localparam int CNT_W    = $clog2(LOCK_MAX + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic             req1,
   input  logic             lock0,
   input  logic             lock1,
   output logic             gnt0,
   output logic             gnt1,
   output owner_t           owner,
   output logic [CNT_W-1:0] lock_cnt
);

   logic last_winner;
   logic grant;
   logic winner;
   logic forced;
   logic other_req;
   logic win_lock;
   logic cnt_full;

   assign cnt_full = (lock_cnt == CNT_W'(LOCK_MAX));

   always_comb begin
      grant  = 1'b0;
      winner = P0;
      forced = 1'b0;
      if (!rst) begin
         if (owner == OWN_P0 && req0) begin
            grant = 1'b1;
            if (cnt_full && req1) begin
               winner = P1;
               forced = 1'b1;
            end else begin
               winner = P0;
            end
         end else if (owner == OWN_P1 && req1) begin
            grant = 1'b1;
            if (cnt_full && req0) begin
               winner = P0;
               forced = 1'b1;
            end else begin
               winner = P1;
            end
         end else if (req0 && req1) begin
            grant  = 1'b1;
            winner = ~last_winner;
         end else if (req0 || req1) begin
            grant  = 1'b1;
            winner = req1 ? P1 : P0;
         end
      end
   end

   assign gnt0      = grant && (winner == P0);
   assign gnt1      = grant && (winner == P1);
   assign other_req = (winner == P0) ? req1 : req0;
   assign win_lock  = (winner == P0) ? lock0 : lock1;

   always_ff @(posedge clk) begin
      if (rst) begin
         last_winner <= P1;
         owner       <= OWN_NONE;
         lock_cnt    <= '0;
      end else begin
         if (grant) begin
            last_winner <= winner;
         end
         if (!grant || forced || !win_lock) begin
            owner    <= OWN_NONE;
            lock_cnt <= '0;
         end else if (owner == owner_of(winner)) begin
            // Owner keeps the port; only grants taken while the other side
            // waits count towards the bound.
            if (other_req && !cnt_full) begin
               lock_cnt <= lock_cnt + 1'b1;
            end
         end else begin
            owner    <= owner_of(winner);
            lock_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port block RAM between the CPU (port 0) and a DMA/debug
// master (port 1).
//   clk, rst                      : clock, synchronous active-high reset
//   mX_req/we/lock/addr/wdata     : port X request
//   mX_gnt                        : port X access accepted this cycle
//   mX_rvalid/rdata               : port X read data, one cycle after gnt
//   ram_we/addr/wdata, ram_rdata  : block RAM interface
//   dbg_owner, dbg_lock_cnt       : arbiter ownership state
// Handshake: a requester raises req with stable we/lock/addr/wdata and holds
// them until it sees gnt; a transfer completes in each cycle with req & gnt.
// A granted read returns exactly one cycle later as rvalid with rdata; writes
// never produce rvalid.
module ram_port_arbiter
   import vscpu_pkg::*;
#(
   parameter  int ADDR_W   = ADDR_W_DEF,
   parameter  int DATA_W   = DATA_W_DEF,
   parameter  int LOCK_MAX = LOCK_MAX_DEF,
   localparam int CNT_W    = $clog2(LOCK_MAX + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic              m0_lock,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic              m1_lock,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output owner_t            dbg_owner,
   output logic [CNT_W-1:0]  dbg_lock_cnt
);

   logic rd_valid_q;
   logic rd_tag_q;

   rr_lock_arbiter #(.LOCK_MAX(LOCK_MAX)) u_arb (
      .clk      (clk),
      .rst      (rst),
      .req0     (m0_req),
      .req1     (m1_req),
      .lock0    (m0_lock),
      .lock1    (m1_lock),
      .gnt0     (m0_gnt),
      .gnt1     (m1_gnt),
      .owner    (dbg_owner),
      .lock_cnt (dbg_lock_cnt)
   );

   always_comb begin
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      if (m0_gnt) begin
         ram_we    = m0_we;
         ram_addr  = m0_addr;
         ram_wdata = m0_wdata;
      end else if (m1_gnt) begin
         ram_we    = m1_we;
         ram_addr  = m1_addr;
         ram_wdata = m1_wdata;
      end
   end

   // The RAM answers a read on the following cycle, so only the owning port
   // tag needs to be carried alongside the valid bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid_q <= 1'b0;
         rd_tag_q   <= P0;
      end else begin
         rd_valid_q <= (m0_gnt && !m0_we) || (m1_gnt && !m1_we);
         rd_tag_q   <= m1_gnt ? P1 : P0;
      end
   end

   // Gating with rst squashes a read that was in flight when reset arrived.
   assign m0_rvalid = rd_valid_q && !rst && (rd_tag_q == P0);
   assign m1_rvalid = rd_valid_q && !rst && (rd_tag_q == P1);
   assign m0_rdata  = m0_rvalid ? ram_rdata : '0;
   assign m1_rdata  = m1_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;
   import vscpu_pkg::*;

   localparam int AW       = 14;
   localparam int DW       = 32;
   localparam int LOCK_MAX = 16;
   localparam int DEPTH    = 1 << AW;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic          m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
   logic [AW-1:0] m0_addr, m1_addr;
   logic [DW-1:0] m0_wdata, m1_wdata;
   logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
   logic [DW-1:0] m0_rdata, m1_rdata;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata, ram_rdata;
   owner_t        dbg_owner;
   logic [4:0]    dbg_lock_cnt;

   ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LOCK_MAX)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .dbg_owner(dbg_owner), .dbg_lock_cnt(dbg_lock_cnt)
   );

   // Block RAM stand-in: 1-cycle synchronous read, read-first on collision.
   logic [DW-1:0] blram [0:DEPTH-1];
   initial for (int i = 0; i < DEPTH; i++) blram[i] = '0;
   always @(posedge clk) begin
      ram_rdata <= blram[ram_addr];
      if (ram_we) blram[ram_addr] <= ram_wdata;
   end

   // ---------------- reference model ----------------
   logic [DW-1:0] ref_mem [0:DEPTH-1];
   int            m_last;     // port that won the previous grant
   int            m_own;      // -1 none, else owning port
   int            m_cnt;
   logic [DW-1:0] exp_q[$];   // pending read data
   int            exp_port_q[$];
   int            m_win;      // model winner of the current cycle, -1 none

   // staging values applied at the next step
   logic s_rst;
   logic s_req [2], s_we [2], s_lock [2];
   logic [AW-1:0] s_addr [2];
   logic [DW-1:0] s_wdata [2];

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_port(input int p, input logic req, input logic we, input logic lock,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
      s_req[p] = req; s_we[p] = we; s_lock[p] = lock; s_addr[p] = addr; s_wdata[p] = wdata;
   endtask

   task automatic idle(input int p);
      set_port(p, 1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   // One clock cycle: drive staged inputs, check against the model, advance the model.
   task automatic step();
      logic          req [2];
      logic [DW-1:0] exp_rd;
      int            exp_rp;
      owner_t        exp_owner;
      @(negedge clk);
      rst = s_rst;
      m0_req = s_req[0]; m0_we = s_we[0]; m0_lock = s_lock[0]; m0_addr = s_addr[0]; m0_wdata = s_wdata[0];
      m1_req = s_req[1]; m1_we = s_we[1]; m1_lock = s_lock[1]; m1_addr = s_addr[1]; m1_wdata = s_wdata[1];
      #1;
      req[0] = s_req[0];
      req[1] = s_req[1];

      // Who gets the RAM this cycle.
      m_win = -1;
      begin
         bit forced = 0;
         if (!s_rst) begin
            if (m_own >= 0 && req[m_own]) begin
               if (m_cnt == LOCK_MAX && req[1 - m_own]) begin
                  m_win = 1 - m_own;
                  forced = 1;
               end else begin
                  m_win = m_own;
               end
            end else if (req[0] && req[1]) m_win = 1 - m_last;
            else if (req[0]) m_win = 0;
            else if (req[1]) m_win = 1;
         end

         // Expected read return from last cycle.
         exp_rd = '0; exp_rp = -1;
         if (exp_q.size() > 0) begin
            exp_rd = exp_q.pop_front();
            exp_rp = exp_port_q.pop_front();
         end
         if (s_rst) begin
            exp_rd = '0; exp_rp = -1;
         end
         exp_owner = (m_own == 0) ? OWN_P0 : (m_own == 1) ? OWN_P1 : OWN_NONE;

         chk("m0_gnt", 64'(m0_gnt), 64'(m_win == 0));
         chk("m1_gnt", 64'(m1_gnt), 64'(m_win == 1));
         chk("ram_we", 64'(ram_we), (m_win >= 0) ? 64'(s_we[m_win]) : 64'd0);
         chk("ram_addr", 64'(ram_addr), (m_win >= 0) ? 64'(s_addr[m_win]) : 64'd0);
         chk("ram_wdata", 64'(ram_wdata), (m_win >= 0) ? 64'(s_wdata[m_win]) : 64'd0);
         chk("m0_rvalid", 64'(m0_rvalid), 64'(exp_rp == 0));
         chk("m1_rvalid", 64'(m1_rvalid), 64'(exp_rp == 1));
         chk("m0_rdata", 64'(m0_rdata), (exp_rp == 0) ? 64'(exp_rd) : 64'd0);
         chk("m1_rdata", 64'(m1_rdata), (exp_rp == 1) ? 64'(exp_rd) : 64'd0);
         chk("owner", 64'(dbg_owner), 64'(exp_owner));
         chk("lock_cnt", 64'(dbg_lock_cnt), 64'(m_cnt));

         // Advance model state.
         if (s_rst) begin
            m_last = 1; m_own = -1; m_cnt = 0;
            exp_q.delete(); exp_port_q.delete();
         end else if (m_win < 0) begin
            m_own = -1; m_cnt = 0;
         end else begin
            if (s_we[m_win]) begin
               ref_mem[s_addr[m_win]] = s_wdata[m_win];
            end else begin
               exp_q.push_back(ref_mem[s_addr[m_win]]);
               exp_port_q.push_back(m_win);
            end
            if (forced || !s_lock[m_win]) begin
               m_own = -1; m_cnt = 0;
            end else if (m_own == m_win) begin
               if (req[1 - m_win] && m_cnt < LOCK_MAX) m_cnt++;
            end else begin
               m_own = m_win; m_cnt = 0;
            end
            m_last = m_win;
         end
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      m_last = 1; m_own = -1; m_cnt = 0; m_win = -1;
      rst = 1'b1;
      m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
      m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;
      idle(0); idle(1);

      // reset with requests pending: nothing may be granted
      s_rst = 1'b1;
      set_port(0, 1, 1, 0, 14'd3, 32'h1234);
      set_port(1, 1, 0, 0, 14'd4, 32'h0);
      run(2);
      idle(0); idle(1);
      s_rst = 1'b0;
      run(1);

      // port 0 write then read-back
      set_port(0, 1, 1, 0, 14'd0, 32'h28014); run(1);
      set_port(0, 1, 0, 0, 14'd0, 32'h0);     run(1);
      idle(0); run(1);

      // preload through port 1
      set_port(1, 1, 1, 0, 14'd10, 32'h14); run(1);
      set_port(1, 1, 1, 0, 14'd20, 32'h32); run(1);
      set_port(1, 1, 1, 0, 14'd5,  32'hA);  run(1);
      idle(1);
      s_rst = 1'b1; run(1); s_rst = 1'b0;

      // both ports reading continuously: alternating grants
      set_port(0, 1, 0, 0, 14'd10, 32'h0);
      set_port(1, 1, 0, 0, 14'd20, 32'h0);
      run(6);
      idle(0); idle(1); run(1);

      // port 1 takes the lock, then port 0 contends
      set_port(1, 1, 0, 1, 14'd7, 32'h0); run(1);
      set_port(0, 1, 0, 0, 14'd10, 32'h0); run(40);
      idle(0); idle(1); run(1);

      // port 0 lock with port 1 idle: no bound applies
      set_port(0, 1, 0, 1, 14'd3, 32'h0); run(25);
      set_port(0, 1, 0, 0, 14'd3, 32'h0); run(1);
      idle(0); run(1);
      set_port(0, 1, 0, 0, 14'd10, 32'h0);
      set_port(1, 1, 0, 0, 14'd20, 32'h0);
      run(1);
      idle(0); idle(1); run(1);

      // reset with a port 1 read in flight
      set_port(1, 1, 0, 0, 14'd20, 32'h0); run(1);
      idle(1); s_rst = 1'b1; run(2); s_rst = 1'b0;
      set_port(0, 1, 0, 0, 14'd10, 32'h0);
      set_port(1, 1, 0, 0, 14'd20, 32'h0);
      run(1);
      idle(0); idle(1); run(1);

      // read-first collision at addr 5
      set_port(0, 1, 0, 0, 14'd5, 32'h0); run(1);
      idle(0); set_port(1, 1, 1, 0, 14'd5, 32'hB); run(1);
      idle(1); set_port(0, 1, 0, 0, 14'd5, 32'h0); run(1);
      idle(0); run(2);

      // random traffic; a requester holds its request until granted
      for (int c = 0; c < 500; c++) begin
         for (int p = 0; p < 2; p++) begin
            if (!(s_req[p] && m_win != p && !s_rst)) begin
               if ($urandom_range(0, 3) != 0)
                  set_port(p, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                           14'($urandom_range(0, 15)), $urandom());
               else
                  idle(p);
            end
         end
         s_rst = ($urandom_range(0, 99) == 0);
         run(1);
      end
      s_rst = 1'b0; idle(0); idle(1); run(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
